// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-outstanding req/ack reads,
// and buffers returned words with their PCs in a shift queue whose head feeds IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    DISCARD = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     pc_d    [DEPTH];
  logic            vld_q   [DEPTH];
  logic            vld_d   [DEPTH];
  logic            pop_s, push_s, space_s;
  logic [CW-1:0]   wr_idx_s;

  // Next-state: queue shift/insert, fetch PC and request FSM
  always_comb begin
    pop_s      = vld_q[0] & ~stall;
    push_s     = (state_q == REQ) & imem_ack & ~redirect;
    wr_idx_s   = count_q - CW'(pop_s);
    instr_d    = instr_q;
    pc_d       = pc_q;
    vld_d      = vld_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;

    // Entries beyond the valid count are kept at zero so the head reads 0 when empty.
    if (redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_d[i] = 32'h0;
        pc_d[i]    = 32'h0;
        vld_d[i]   = 1'b0;
      end
      count_d    = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          instr_d[i] = instr_q[i+1];
          pc_d[i]    = pc_q[i+1];
          vld_d[i]   = vld_q[i+1];
        end
        instr_d[DEPTH-1] = 32'h0;
        pc_d[DEPTH-1]    = 32'h0;
        vld_d[DEPTH-1]   = 1'b0;
      end else begin
        vld_d = vld_q;
      end
      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx_s) begin
            instr_d[i] = imem_rdata;
            pc_d[i]    = fetch_pc_q;
            vld_d[i]   = 1'b1;
          end else begin
            vld_d[i] = vld_d[i];
          end
        end
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      count_d = count_q - CW'(pop_s) + CW'(push_s);
    end

    space_s = (count_d < CW'(DEPTH));

    case (state_q)
      IDLE: begin
        if (redirect || space_s) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_d;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (space_s) begin
            state_d = REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end else begin
          state_d = REQ;
        end
      end
      // Stale read still in flight: its data is dropped, then fetch the latest target.
      DISCARD: begin
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = fetch_pc_d;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
        vld_q[i]   <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      vld_q      <= vld_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr_out = instr_q[0];
  assign pc_out    = pc_q[0];
  assign valid_out = vld_q[0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized stall/ack/redirect/reset,
// checked against an in-order instruction-stream model (next expected PC and memory image).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, pc_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = 32'h0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then check against the stream model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input int mode, input logic rst);
    logic        pv, preq, pack;
    logic [31:0] ppc, pins, paddr;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    reset       = rst;
    case (mode)
      0:       pack = 1'b0;
      1:       pack = imem_req;
      default: pack = imem_req & ($urandom_range(0, 1) == 1);
    endcase
    imem_ack   = pack;
    imem_rdata = pack ? mem_word(imem_addr) : $urandom();
    pv = valid_out; ppc = pc_out; pins = instr_out; preq = imem_req; paddr = imem_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      exp_pc = 32'h0;
    end else begin
      if (rd) begin
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        exp_pc = rpc & 32'hFFFF_FFFC;
      end else if (pv && !st) begin
        chk("retire_pc", ppc, exp_pc);
        chk("retire_instr", pins, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end else if (pv && st) begin
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        chk("hold_pc", pc_out, ppc);
        chk("hold_instr", instr_out, pins);
      end
      if (preq && !pack) begin
        chk("req_held", {31'd0, imem_req}, 32'd1);
        chk("addr_held", imem_addr, paddr);
      end
    end
    if (!valid_out) begin
      chk("empty_pc", pc_out, 32'h0);
      chk("empty_instr", instr_out, 32'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // reset and zero-wait streaming from RESET_PC
    step(1'b0, 1'b0, 32'h0, 0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("first_valid", {31'd0, valid_out}, 32'd1);
    chk("first_pc", pc_out, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);

    // redirect while the read at 0x20 is pending
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h20); i++)
      step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("find_0x20", imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0103, 0, 1'b0);
    chk("discard_addr", imem_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("retarget_addr", imem_addr, 32'h100);
    chk("retarget_req", {31'd0, imem_req}, 32'd1);
    chk("dropped_valid", {31'd0, valid_out}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("target_pc", pc_out, 32'h100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);

    // redirect coinciding with imem_ack
    step(1'b0, 1'b1, 32'h0000_0200, 1, 1'b0);
    chk("ack_redir_addr", imem_addr, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("ack_redir_pc", pc_out, 32'h200);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);

    // stall fills the queue and idles fetch; release resumes the stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
    chk("stall_req_drop", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("resume_valid", {31'd0, valid_out}, 32'd1);

    // PC wrap past 32'hFFFF_FFFC
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("wrap_pc0", pc_out, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("wrap_pc1", pc_out, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("wrap_pc2", pc_out, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1, 1'b0);

    // randomized stall / ack / redirect / reset
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 29) == 0), $urandom(), 2,
           ($urandom_range(0, 99) == 0));

    // reset with a request outstanding
    for (int i = 0; i < 6 && !imem_req; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0);
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 0, 1'b0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);
    chk("restart_valid", {31'd0, valid_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
